uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 8, data bits per received frame.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-003 SHALL have derived localparam ADDR_WIDTH = log2(DEPTH), pointer width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port rx_data  input  FRAME_WIDTH  frame from UART receiver, valid when rx_done=1.
REQ-007 SHALL have port rx_done  input  1  one-cycle frame-complete strobe from UART receiver.
REQ-008 SHALL have port rx_err  input  1  framing error for the frame strobed by rx_done; sampled only with rx_done.
REQ-009 SHALL have port rd_en  input  1  consumer read request.
REQ-010 SHALL have port clr  input  1  clears sticky flags overflow and frame_err.
REQ-011 SHALL have port rd_data  output  FRAME_WIDTH  registered head entry of a read.
REQ-012 SHALL have port rd_valid  output  1  one-cycle strobe; rd_data is new this cycle.
REQ-013 SHALL have port empty  output  1  count == 0.
REQ-014 SHALL have port full  output  1  count == DEPTH.
REQ-015 SHALL have port count  output  ADDR_WIDTH+1  stored entries, 0..DEPTH.
REQ-016 SHALL have port overflow  output  1  sticky; a good frame was dropped because the FIFO was full.
REQ-017 SHALL have port frame_err  output  1  sticky; a frame was dropped because rx_err=1.

Function
REQ-018 SHALL accept a write in a cycle where rx_done=1, rx_err=0, and either full=0 or rd_en=1; rx_data goes to mem[wr_ptr] and wr_ptr advances.
REQ-019 SHALL discard the frame in a cycle where rx_done=1 and rx_err=1, and set frame_err the next edge.
REQ-020 SHALL discard the frame in a cycle where rx_done=1, rx_err=0, full=1 and rd_en=0, and set overflow the next edge; stored contents stay unchanged.
REQ-021 SHALL accept a read in a cycle where rd_en=1 and empty=0: rd_data <= mem[rd_ptr], rd_ptr advances, and rd_valid=1 the following cycle (1-cycle latency).
REQ-022 SHALL ignore rd_en when empty=0 is false: no pointer change, rd_valid stays 0, rd_data holds; a same-cycle write is accepted with no fall-through.
REQ-023 SHALL, on simultaneous accepted read and write, perform both with count unchanged, including when full.
REQ-024 SHALL change count by +1 on write only, -1 on read only, 0 on both or neither; empty and full are combinational from count.
REQ-025 SHALL wrap both pointers modulo DEPTH, with no gap or duplicate at wrap.
REQ-026 SHALL hold rd_data between reads and drive rd_valid low in every cycle without an accepted read.
REQ-027 SHALL set sticky flags until clr=1; clr clears them on the next edge, and a same-cycle set event wins over clr.
REQ-028 SHALL treat rx_err as don't-care when rx_done=0.

Reset
REQ-029 SHALL, while rst=0, immediately force wr_ptr, rd_ptr, count, rd_data, rd_valid, overflow and frame_err to 0, so empty=1 and full=0.
REQ-030 SHALL leave memory contents unreset and unobservable until rewritten.
REQ-031 SHALL, on reset mid-operation, lose all stored frames; the first write after release lands at entry 0.

Verification
REQ-032 Bench SHALL cover: reset, then rx_data=0x6C and 0xAF each with rx_done, then two rd_en -> rd_data 0x6C then 0xAF, each with a 1-cycle rd_valid; count goes 0,1,2,1,0.
REQ-033 Bench SHALL cover: 9 good frames 0x01..0x09 with DEPTH=8 -> full=1 after the 8th, 9th dropped, overflow=1; 8 reads return 0x01..0x08, then empty=1.
REQ-034 Bench SHALL cover: rx_done with rx_err=1 and data 0x55 -> count unchanged, frame_err=1; clr pulse -> frame_err=0; clr concurrent with a new error -> frame_err stays 1.
REQ-035 Bench SHALL cover: full FIFO with rx_done=1 (0xA5) and rd_en=1 in the same cycle -> oldest entry read, 0xA5 stored, count stays 8, overflow stays 0.
REQ-036 Bench SHALL cover: 20 write/read pairs streamed through the wrap -> data order preserved; rd_en while empty -> rd_valid=0, rd_data unchanged.
REQ-037 Bench SHALL cover: rst asserted with count=5 -> count=0, empty=1, rd_valid=0 asynchronously; after release, write 0x3C then read -> 0x3C.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: buffers good frames, drops errored or
// overflowing frames and records each kind of drop in its own sticky flag.
module uart_rx_fifo #(
   parameter  int FRAME_WIDTH = 8,
   parameter  int DEPTH       = 8,
   localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [FRAME_WIDTH-1:0] rx_data,
   input  logic                   rx_done,
   input  logic                   rx_err,
   input  logic                   rd_en,
   input  logic                   clr,
   output logic [FRAME_WIDTH-1:0] rd_data,
   output logic                   rd_valid,
   output logic                   empty,
   output logic                   full,
   output logic [ADDR_WIDTH:0]    count,
   output logic                   overflow,
   output logic                   frame_err
);

   localparam logic [ADDR_WIDTH:0]   C_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = (ADDR_WIDTH+1)'(32'd1);
   localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(32'd1);

   logic [FRAME_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0]  r_wr_ptr;
   logic [ADDR_WIDTH-1:0]  r_rd_ptr;
   logic [ADDR_WIDTH:0]    r_count;
   logic [FRAME_WIDTH-1:0] r_rd_data;
   logic                   r_rd_valid;
   logic                   r_overflow;
   logic                   r_frame_err;

   logic w_empty;
   logic w_full;
   logic w_good_frame;
   logic w_rd_accept;
   logic w_wr_accept;
   logic w_overflow_evt;
   logic w_frame_err_evt;

   assign w_empty = (r_count == {(ADDR_WIDTH+1){1'b0}});
   assign w_full  = (r_count == C_DEPTH);

   // A read frees the head slot in the same edge, so a full FIFO can still take a write when rd_en=1.
   assign w_good_frame    = rx_done & ~rx_err;
   assign w_rd_accept     = rd_en & ~w_empty;
   assign w_wr_accept     = w_good_frame & (~w_full | rd_en);
   assign w_overflow_evt  = w_good_frame & w_full & ~rd_en;
   assign w_frame_err_evt = rx_done & rx_err;

   // Storage array; deliberately not reset, contents are only visible after being written.
   always_ff @(posedge clk) begin
      if (w_wr_accept) begin
         r_mem[r_wr_ptr] <= rx_data;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= {ADDR_WIDTH{1'b0}};
         r_rd_ptr <= {ADDR_WIDTH{1'b0}};
         r_count  <= {(ADDR_WIDTH+1){1'b0}};
      end else begin
         if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_rd_accept) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         case ({w_wr_accept, w_rd_accept})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Read port: data holds between reads, valid is a single-cycle strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_data  <= {FRAME_WIDTH{1'b0}};
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_accept;
         if (w_rd_accept) begin
            r_rd_data <= r_mem[r_rd_ptr];
         end
      end
   end

   // Sticky drop flags; a set event in the same cycle as clr takes priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_overflow_evt) begin
            r_overflow <= 1'b1;
         end else if (clr) begin
            r_overflow <= 1'b0;
         end
         if (w_frame_err_evt) begin
            r_frame_err <= 1'b1;
         end else if (clr) begin
            r_frame_err <= 1'b0;
         end
      end
   end

   assign rd_data   = r_rd_data;
   assign rd_valid  = r_rd_valid;
   assign empty     = w_empty;
   assign full      = w_full;
   assign count     = r_count;
   assign overflow  = r_overflow;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_fifo;

   localparam int FW    = 8;
   localparam int DEPTH = 8;

   logic         clk       = 1'b0;
   logic         rst       = 1'b0;
   logic [FW-1:0] rx_data  = 8'h00;
   logic         rx_done   = 1'b0;
   logic         rx_err    = 1'b0;
   logic         rd_en     = 1'b0;
   logic         clr       = 1'b0;
   logic [FW-1:0] rd_data;
   logic         rd_valid;
   logic         empty;
   logic         full;
   logic [3:0]   count;
   logic         overflow;
   logic         frame_err;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   // reference model state
   logic [FW-1:0] m_q[$];
   logic [FW-1:0] m_rd_data  = 8'h00;
   bit            m_rd_valid = 1'b0;
   bit            m_ovf      = 1'b0;
   bit            m_ferr     = 1'b0;
   bit            m_rd_ok;
   bit            m_wr_ok;
   logic [FW-1:0] last_data;

   uart_rx_fifo #(.FRAME_WIDTH(FW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .rx_err   (rx_err),
      .rd_en    (rd_en),
      .clr      (clr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: a frame queue plus flags
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q.delete();
         m_rd_data  = 8'h00;
         m_rd_valid = 1'b0;
         m_ovf      = 1'b0;
         m_ferr     = 1'b0;
      end else begin
         m_rd_ok = rd_en && (m_q.size() > 0);
         m_wr_ok = rx_done && !rx_err && ((m_q.size() < DEPTH) || rd_en);
         m_rd_valid = m_rd_ok;
         if (m_rd_ok) m_rd_data = m_q.pop_front();
         if (m_wr_ok) m_q.push_back(rx_data);
         if (rx_done && !rx_err && !m_wr_ok) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
         if (rx_done && rx_err) m_ferr = 1'b1;
         else if (clr) m_ferr = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("count",     32'(count),     32'(m_q.size()));
         chk("empty",     32'(empty),     32'(m_q.size() == 0));
         chk("full",      32'(full),      32'(m_q.size() == DEPTH));
         chk("rd_valid",  32'(rd_valid),  32'(m_rd_valid));
         chk("rd_data",   32'(rd_data),   32'(m_rd_data));
         chk("overflow",  32'(overflow),  32'(m_ovf));
         chk("frame_err", 32'(frame_err), 32'(m_ferr));
      end
   end

   task automatic cyc(input logic d_done, input logic [FW-1:0] d, input logic e,
                      input logic r, input logic c);
      rx_done = d_done;
      rx_data = d;
      rx_err  = e;
      rd_en   = r;
      clr     = c;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      rx_err  = 1'b0;
      rd_en   = 1'b0;
      clr     = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_flags", 32'({overflow, frame_err}), 32'd0);
      cmp_en = 1'b1;

      // basic write/read pair
      cyc(1'b1, 8'h6C, 1'b0, 1'b0, 1'b0);  chk("b_cnt1", 32'(count), 32'd1);
      cyc(1'b1, 8'hAF, 1'b0, 1'b0, 1'b0);  chk("b_cnt2", 32'(count), 32'd2);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("b_rd1", 32'(rd_data), 32'h6C); chk("b_v1", 32'(rd_valid), 32'd1); chk("b_cnt3", 32'(count), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);  chk("b_v1off", 32'(rd_valid), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("b_rd2", 32'(rd_data), 32'hAF); chk("b_v2", 32'(rd_valid), 32'd1); chk("b_cnt4", 32'(count), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("b_v2off", 32'(rd_valid), 32'd0); chk("b_empty", 32'(empty), 32'd1);

      // overflow
      for (int i = 1; i <= 9; i++) begin
         cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         if (i == 8) chk("o_full8", 32'(full), 32'd1);
      end
      chk("o_cnt", 32'(count), 32'd8); chk("o_ovf", 32'(overflow), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         chk("o_rd", 32'(rd_data), 32'(i)); chk("o_v", 32'(rd_valid), 32'd1);
      end
      chk("o_empty", 32'(empty), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);  chk("o_clr", 32'(overflow), 32'd0);

      // framing errors and clr priority
      cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      chk("f_cnt", 32'(count), 32'd0); chk("f_set", 32'(frame_err), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);  chk("f_clr", 32'(frame_err), 32'd0);
      cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);  chk("f_win", 32'(frame_err), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // full with simultaneous read/write
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
      chk("s_rd", 32'(rd_data), 32'h10); chk("s_cnt", 32'(count), 32'd8); chk("s_ovf", 32'(overflow), 32'd0);
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         chk("s_drain", 32'(rd_data), (i == 8) ? 32'hA5 : 32'(8'h10 + i));
      end

      // streaming through the wrap
      cyc(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 1'b0);
         chk("w_rd", 32'(rd_data), 32'(8'h40 + i - 1)); chk("w_cnt", 32'(count), 32'd1);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);  chk("w_last", 32'(rd_data), 32'h54);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("e_v", 32'(rd_valid), 32'd0); chk("e_hold", 32'(rd_data), 32'h54);

      // asynchronous reset mid-operation
      for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);  chk("r_cnt5", 32'(count), 32'd5);
      rst = 1'b0;
      #1;
      chk("r_cnt", 32'(count), 32'd0); chk("r_empty", 32'(empty), 32'd1); chk("r_v", 32'(rd_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);  chk("r_rd", 32'(rd_data), 32'h3C);

      // randomized traffic with alternating fill/drain bias
      for (int i = 0; i < 2000; i++) begin
         last_data = 8'($urandom);
         if (((i / 100) % 2) == 0)
            cyc(1'($urandom_range(0, 9) < 7), last_data, 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0));
         else
            cyc(1'($urandom_range(0, 9) < 3), last_data, 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
